uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUDRATE, default 125000000/115200, meaning clock cycles per bit period (minimum 4).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line (idle high).
REQ-005 SHALL have port data, output, data_t (8), last received byte.
REQ-006 SHALL have port rcv, output, 1, one-cycle pulse marking a completed frame.
REQ-007 SHALL have port par_err, output, 1, parity mismatch flag for the last frame.
REQ-008 SHALL have port frm_err, output, 1, stop-bit-low flag for the last frame.
REQ-009 SHALL have port busy, output, 1, high while a frame is being received (state not IDLE).

Function
REQ-010 SHALL accept frame format: start (0), 8 data bits LSB first, even parity bit (XOR of data), stop (1); this is the same format uart_tx sends.
REQ-011 SHALL pass rx through a 2-flop synchronizer; all logic SHALL use the synchronized value rx_s.
REQ-012 SHALL detect a start edge as rx_s 1->0 between consecutive cycles; a line held low SHALL NOT produce repeated starts.
REQ-013 SHALL implement the FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
REQ-014 IDLE: on a start edge at cycle T0, SHALL load the baud counter with BAUDRATE/2 (integer division) and enter START.
REQ-015 START: at the half-bit tick, if rx_s=0 SHALL enter DATA; otherwise SHALL treat it as a glitch and return to IDLE with no output change.
REQ-016 Baud ticks after START SHALL occur every BAUDRATE cycles; each tick samples rx_s once.
REQ-017 DATA: SHALL shift 8 samples LSB first using a 3-bit bit counter, then enter PARITY after the 8th sample.
REQ-018 PARITY: SHALL sample the parity bit, then enter STOP.
REQ-019 STOP: on its sample, SHALL load data from the shift register and set par_err/frm_err, then return to IDLE.
REQ-020 rcv SHALL pulse exactly at cycle T0 + BAUDRATE/2 + 10*BAUDRATE + 1, for every completed frame, including frames with errors.
REQ-021 data, par_err and frm_err SHALL hold until the next completed frame.
REQ-022 frm_err SHALL be 1 iff the stop sample is 0.
REQ-023 After a framing error, a new frame SHALL start only after a fresh 1->0 edge.
REQ-024 Back-to-back frames, with the next start edge immediately after the stop bit, SHALL be received without loss.

Reset
REQ-025 On rst=1 at a clock edge, SHALL set FSM=IDLE, counters=0, shift register=0, synchronizer flops=1, data=0, rcv=0, par_err=0, frm_err=0, busy=0.
REQ-026 Reset mid-frame SHALL abort the frame with no rcv pulse; reception SHALL resume on the next start edge after rst falls.

Configuration
REQ-027 With macro UART_RX_PARITY_CHECK_EN defined, SHALL compare the parity sample against the XOR of the data bits and set par_err on mismatch.
REQ-028 Without UART_RX_PARITY_CHECK_EN, SHALL still consume the parity bit period (same frame timing) and SHALL tie par_err to 0.

Structure
REQ-029 pkg_uart SHALL hold data_t, DATA_BITS=8, the FSM enum rx_state_e, and the wire bundle struct st_uart_rx.
REQ-030 Baud timing SHALL be a sub-module baudgen_rx (enable, half-bit load, tick output).
REQ-031 The parity calculation SHALL reuse parity_bit_gen.

Verification
REQ-032 Use BAUDRATE=16: send 0xA5, parity 0, stop 1 -> data=0xA5, rcv pulse at T0+169, par_err=0, frm_err=0.
REQ-033 Send 0x01 with parity bit 0 -> data=0x01, par_err=1 when UART_RX_PARITY_CHECK_EN is defined, par_err=0 when it is not.
REQ-034 Send 0x3C with stop bit 0 -> rcv pulse, frm_err=1; then send 0x00 after the line returns high -> data=0x00, frm_err=0.
REQ-035 Drive a 5-cycle low glitch on an idle line -> no rcv pulse, busy returns to 0 by T0+9.
REQ-036 Assert rst for 1 cycle during data bit 4 of 0xFF, then send 0x55 -> no pulse for 0xFF, data=0x55.
REQ-037 Loop uart_tx to uart_rx and send 0x00, 0xFF, 0x5A back-to-back -> 3 rcv pulses with matching data and no errors.

Source files
------------

// File: rtl/pkg_uart.sv
// Shared types for the UART receiver: data word, receive FSM states and output bundle.
package pkg_uart;

  localparam int unsigned DATA_BITS = 8;

  typedef logic [DATA_BITS-1:0] data_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  typedef struct packed {
    data_t data;
    logic  rcv;
    logic  par_err;
    logic  frm_err;
    logic  busy;
  } st_uart_rx;

endpackage

// File: rtl/baudgen_rx.sv
// Receive baud generator: loads a half-bit count on a start edge, then ticks every BAUDRATE cycles.
module baudgen_rx #(
  parameter int unsigned BAUDRATE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_load_half,
  output logic o_tick
);

  localparam int unsigned CW   = $clog2(BAUDRATE + 1);
  localparam int unsigned HALF = BAUDRATE / 2;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Tick is registered, so the FSM acts on it one cycle after the count expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_load_half) begin
        r_cnt <= CW'(HALF);
      end else if (i_en) begin
        if (r_cnt <= CW'(1)) begin
          r_cnt  <= CW'(BAUDRATE);
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/parity_bit_gen.sv
// Even parity of a data word (XOR of all bits), purely combinational.
module parity_bit_gen #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_data,
  output logic         o_parity_c
);

  assign o_parity_c = ^i_data;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop.
// Define UART_RX_PARITY_CHECK_EN to flag parity mismatches on par_err.
module uart_rx
  import pkg_uart::*;
#(
  parameter int unsigned BAUDRATE = 125000000 / 115200
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rx,
  output data_t data,
  output logic  rcv,
  output logic  par_err,
  output logic  frm_err,
  output logic  busy
);

  logic [1:0] r_sync;
  logic       r_rx_prev;
  rx_state_e  r_state;
  logic [2:0] r_bit_cnt;
  data_t      r_shift;
  st_uart_rx  r_out;

  logic w_rx_s;
  logic w_start_edge;
  logic w_load_half;
  logic w_en;
  logic w_tick;

  assign w_rx_s       = r_sync[1];
  assign w_start_edge = r_rx_prev & ~w_rx_s;
  assign w_load_half  = (r_state == S_IDLE) && w_start_edge;
  assign w_en         = (r_state != S_IDLE);

  baudgen_rx #(
    .BAUDRATE(BAUDRATE)
  ) u_baudgen (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_en),
    .i_load_half(w_load_half),
    .o_tick     (w_tick)
  );

`ifdef UART_RX_PARITY_CHECK_EN
  logic r_par_sample;
  logic w_calc_par;

  parity_bit_gen #(
    .W(DATA_BITS)
  ) u_parity (
    .i_data    (r_shift),
    .o_parity_c(w_calc_par)
  );
`endif

  // Synchronizer, edge tracking and the receive FSM share one register block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_out     <= '0;
`ifdef UART_RX_PARITY_CHECK_EN
      r_par_sample <= 1'b0;
`endif
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_rx_prev <= w_rx_s;
      r_out.rcv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state    <= S_START;
            r_out.busy <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state    <= S_IDLE;
              r_out.busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
              r_state <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
`ifdef UART_RX_PARITY_CHECK_EN
            r_par_sample <= w_rx_s;
`endif
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_out.data    <= r_shift;
            r_out.rcv     <= 1'b1;
            r_out.frm_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_CHECK_EN
            r_out.par_err <= r_par_sample ^ w_calc_par;
`else
            r_out.par_err <= 1'b0;
`endif
            r_out.busy    <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_out.busy <= 1'b0;
        end
      endcase
    end
  end

  assign data    = r_out.data;
  assign rcv     = r_out.rcv;
  assign par_err = r_out.par_err;
  assign frm_err = r_out.frm_err;
  assign busy    = r_out.busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUDRATE=16: frames, errors, glitch, mid-frame reset, back-to-back.
module tb_uart_rx;

  localparam int unsigned B = 16;
  // Sync (2) + edge detect (1) + half bit + 10 bits + registered tick (1).
  localparam int unsigned LAT = 3 + B / 2 + 10 * B + 1;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       frm;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       par_err;
  logic       frm_err;
  logic       busy;

  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t q[$];

  uart_rx #(
    .BAUDRATE(B)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .data   (data),
    .rcv    (rcv),
    .par_err(par_err),
    .frm_err(frm_err),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each rcv pulse retires one expected frame; an unmatched pulse is an error.
  always @(negedge clk) begin
    exp_t e;
    if (rcv) begin
      if (q.size() == 0) begin
        chk("spurious_rcv", 32'(rcv), 32'd0);
      end else begin
        e = q.pop_front();
        chk("data", 32'(data), 32'(e.data));
        chk("par_err", 32'(par_err), 32'(e.par));
        chk("frm_err", 32'(frm_err), 32'(e.frm));
        chk("rcv_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic bit_time(input logic b);
    rx = b;
    repeat (B) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    e.data = d;
    e.par  = PEN ? (p != ^d) : 1'b0;
    e.frm  = ~s;
    e.cyc  = cyc + int'(LAT);
    q.push_back(e);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(p);
    bit_time(s);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 40 * B;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] d;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_rcv", 32'(rcv), 32'd0);
    chk("rst_par", 32'(par_err), 32'd0);
    chk("rst_frm", 32'(frm_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(4);

    send_frame(8'hA5, 1'b0, 1'b1);
    wait_drain();
    idle(B);

    send_frame(8'h01, 1'b0, 1'b1);
    wait_drain();
    idle(B);

    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2 * B);
    wait_drain();
    chk("hold_data", 32'(data), 32'h3C);
    chk("hold_frm", 32'(frm_err), 32'd1);
    send_frame(8'h00, 1'b0, 1'b1);
    wait_drain();
    idle(B);

    // Five-cycle low glitch on an idle line.
    n = cyc;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    wait_cyc(n + 3);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    wait_cyc(n + 12);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    idle(12 * B);

    // 0xFF aborted by reset in data bit 4; sender also abandons the frame.
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rx = 1'b1;
    repeat (B / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(12 * B);
    chk("abort_busy", 32'(busy), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_drain();
    idle(B);

    // Back-to-back, next start bit right after each stop bit.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, ^d, 1'b1);
    end
    idle(4);
    wait_drain();
    idle(2 * B);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
